// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage MIPS pipeline.
// Decodes the instruction in MEM, muxes forwarded store data, performs
// word/byte data-memory access and selects the writeback value.
// Optional feature macro: DM_TRACE_EN (prints every committed store).
module mem_stage #(
   parameter int unsigned DM_AW = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr,
   input  logic [31:0] PC,
   input  logic [31:0] MemAddr,
   input  logic [31:0] GRFRData2,
   input  logic [31:0] W_GRFWData,
   input  logic [31:0] ALUResult,
   input  logic [1:0]  Trans_MemRD_Sel,
   output logic [31:0] GRFWData,
   output logic [4:0]  ReadA1,
   output logic [4:0]  ReadA2,
   output logic [4:0]  WriteA,
   output logic        RegWrite
);

   localparam int unsigned DEPTH = 2 ** DM_AW;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   logic [31:0]      mem_q [DEPTH];

   logic [5:0]       opcode_c;
   logic [5:0]       funct_c;
   logic             mem_to_reg_c;
   logic             mem_write_c;
   logic             is_memb_c;
   logic [DM_AW-1:0] mem_idx_c;
   logic [4:0]       lane_sh_c;
   logic [31:0]      mem_wdata_c;
   logic [31:0]      rd_word_c;
   logic [7:0]       rd_byte_c;
   logic [31:0]      load_data_c;
   logic [31:0]      merged_word_c;
   logic             unused_ok;

   assign opcode_c  = Instr[31:26];
   assign funct_c   = Instr[5:0];
   assign ReadA1    = Instr[25:21];
   assign ReadA2    = Instr[20:16];
   assign mem_idx_c = MemAddr[DM_AW+1:2];
   assign lane_sh_c = {MemAddr[1:0], 3'b000};

   // Bits that only feed the trace or are architecturally ignored
   assign unused_ok = ^{PC, MemAddr[31:DM_AW+2], Instr[10:6]};

   // Instruction decode into register-file and memory controls
   always_comb begin
      WriteA       = 5'd0;
      RegWrite     = 1'b0;
      mem_to_reg_c = 1'b0;
      mem_write_c  = 1'b0;
      is_memb_c    = 1'b0;
      case (opcode_c)
         OP_RTYPE: begin
            if (funct_c == FN_ADDU || funct_c == FN_SUBU) begin
               WriteA   = Instr[15:11];
               RegWrite = 1'b1;
            end
         end
         OP_ORI, OP_LUI: begin
            WriteA   = Instr[20:16];
            RegWrite = 1'b1;
         end
         OP_LW, OP_LB: begin
            WriteA       = Instr[20:16];
            RegWrite     = 1'b1;
            mem_to_reg_c = 1'b1;
            is_memb_c    = (opcode_c == OP_LB);
         end
         OP_SW, OP_SB: begin
            mem_write_c = 1'b1;
            is_memb_c   = (opcode_c == OP_SB);
         end
         OP_JAL: begin
            WriteA   = 5'd31;
            RegWrite = 1'b1;
         end
         default: ;
      endcase
   end

   // Store-data forwarding mux
   always_comb begin
      case (Trans_MemRD_Sel)
         2'd0:    mem_wdata_c = GRFRData2;
         2'd1:    mem_wdata_c = W_GRFWData;
         default: mem_wdata_c = 32'd0;
      endcase
   end

   // Combinational read path and writeback select
   always_comb begin
      rd_word_c   = mem_q[mem_idx_c];
      rd_byte_c   = 8'(rd_word_c >> lane_sh_c);
      load_data_c = is_memb_c ? {{24{rd_byte_c[7]}}, rd_byte_c} : rd_word_c;
      GRFWData    = mem_to_reg_c ? load_data_c : ALUResult;
   end

   // Byte stores overwrite a single lane of the currently stored word
   always_comb begin
      merged_word_c = mem_wdata_c;
      if (is_memb_c) begin
         merged_word_c                 = rd_word_c;
         merged_word_c[lane_sh_c +: 8] = mem_wdata_c[7:0];
      end
   end

   // Memory array: synchronous clear has priority over stores
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i[DM_AW-1:0]] <= '0;
         end
      end else if (mem_write_c) begin
         mem_q[mem_idx_c] <= merged_word_c;
`ifdef DM_TRACE_EN
         $display("%d@%h: *%h <= %h", $time, PC, {MemAddr[31:2], 2'b00}, merged_word_c);
`endif
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector table, hand-written reset corner and
// randomized traffic checked against a byte-addressed memory model.
module tb_mem_stage;

   logic        clk;
   logic        reset;
   logic [31:0] Instr, PC, MemAddr, GRFRData2, W_GRFWData, ALUResult;
   logic [1:0]  Trans_MemRD_Sel;
   logic [31:0] GRFWData;
   logic [4:0]  ReadA1, ReadA2, WriteA;
   logic        RegWrite;

   int checks   = 0;
   int failures = 0;

   // byte-addressed view of the 16 KiB data memory
   logic [7:0] mb [0:16383];

   mem_stage dut (
      .clk             (clk),
      .reset           (reset),
      .Instr           (Instr),
      .PC              (PC),
      .MemAddr         (MemAddr),
      .GRFRData2       (GRFRData2),
      .W_GRFWData      (W_GRFWData),
      .ALUResult       (ALUResult),
      .Trans_MemRD_Sel (Trans_MemRD_Sel),
      .GRFWData        (GRFWData),
      .ReadA1          (ReadA1),
      .ReadA2          (ReadA2),
      .WriteA          (WriteA),
      .RegWrite        (RegWrite)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [31:0] addr;
      logic [31:0] r2;
      logic [31:0] ww;
      logic [31:0] alu;
      logic [1:0]  sel;
      int          wr;      // 0 none, 1 word store, 2 byte store
      logic [31:0] exp_d;
      logic [4:0]  exp_wa;
      logic        exp_rw;
   } vec_t;

   function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] model_word(input logic [31:0] addr);
      logic [13:0] w;
      w = {addr[13:2], 2'b00};
      return {mb[w + 14'd3], mb[w + 14'd2], mb[w + 14'd1], mb[w]};
   endfunction

   function automatic logic [31:0] model_byte(input logic [31:0] addr);
      logic [7:0] b;
      b = mb[addr[13:0]];
      return {{24{b[7]}}, b};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 16384; i++) mb[i] = 8'h00;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Drive one instruction, check outputs before the edge, then commit the model
   task automatic step(input string nm, input logic [31:0] instr, input logic [31:0] addr,
                       input logic [31:0] r2, input logic [31:0] ww, input logic [31:0] alu,
                       input logic [1:0] sel, input logic rst, input int wr,
                       input logic [31:0] exp_d, input logic [4:0] exp_wa, input logic exp_rw);
      logic [31:0] sd;
      logic [13:0] w;
      Instr = instr; MemAddr = addr; GRFRData2 = r2; W_GRFWData = ww;
      ALUResult = alu; Trans_MemRD_Sel = sel; reset = rst; PC = PC + 32'd4;
      #1;
      chk({nm, ".GRFWData"}, GRFWData, exp_d);
      chk({nm, ".WriteA"}, 32'(WriteA), 32'(exp_wa));
      chk({nm, ".RegWrite"}, 32'(RegWrite), 32'(exp_rw));
      chk({nm, ".ReadA"}, {22'd0, ReadA1, ReadA2}, {22'd0, instr[25:21], instr[20:16]});
      @(posedge clk);
      sd = (sel == 2'd0) ? r2 : (sel == 2'd1) ? ww : 32'd0;
      w  = {addr[13:2], 2'b00};
      if (!rst) model_clear();
      else if (wr == 1) begin
         mb[w] = sd[7:0]; mb[w + 14'd1] = sd[15:8];
         mb[w + 14'd2] = sd[23:16]; mb[w + 14'd3] = sd[31:24];
      end else if (wr == 2) mb[addr[13:0]] = sd[7:0];
      #1;
   endtask

   vec_t vecs[21];

   initial begin
      logic [31:0] instr, addr, r2, ww, alu, exp_d;
      logic [4:0]  rs, rt, rd, exp_wa;
      logic [1:0]  sel;
      logic        exp_rw, rst;
      int          k, wr;
      logic [5:0]  bad_ops [7];

      bad_ops = '{6'h01, 6'h05, 6'h08, 6'h0c, 6'h21, 6'h29, 6'h3f};

      vecs[0]  = '{"lw0",     enc_i(6'h23, 5'd1, 5'd8,  16'h0),    32'h0000_0000, 32'h0, 32'h0, 32'hA000_0000, 2'd0, 0, 32'h0000_0000, 5'd8,  1'b1};
      vecs[1]  = '{"lw3ffc",  enc_i(6'h23, 5'd1, 5'd9,  16'h0),    32'h0000_3FFC, 32'h0, 32'h0, 32'hA000_0001, 2'd0, 0, 32'h0000_0000, 5'd9,  1'b1};
      vecs[2]  = '{"sw10",    enc_i(6'h2b, 5'd2, 5'd10, 16'h10),   32'h0000_0010, 32'h1234_5678, 32'h0, 32'hA000_0002, 2'd0, 1, 32'hA000_0002, 5'd0, 1'b0};
      vecs[3]  = '{"lw10a",   enc_i(6'h23, 5'd2, 5'd11, 16'h10),   32'h0000_0010, 32'h0, 32'h0, 32'hA000_0003, 2'd0, 0, 32'h1234_5678, 5'd11, 1'b1};
      vecs[4]  = '{"sb11",    enc_i(6'h28, 5'd2, 5'd12, 16'h11),   32'h0000_0011, 32'h0000_FFFF, 32'h0000_00AB, 32'hA000_0004, 2'd1, 2, 32'hA000_0004, 5'd0, 1'b0};
      vecs[5]  = '{"lw10b",   enc_i(6'h23, 5'd2, 5'd13, 16'h10),   32'h0000_0010, 32'h0, 32'h0, 32'hA000_0005, 2'd0, 0, 32'h1234_AB78, 5'd13, 1'b1};
      vecs[6]  = '{"lb11",    enc_i(6'h20, 5'd2, 5'd14, 16'h11),   32'h0000_0011, 32'h0, 32'h0, 32'hA000_0006, 2'd0, 0, 32'hFFFF_FFAB, 5'd14, 1'b1};
      vecs[7]  = '{"lb13",    enc_i(6'h20, 5'd2, 5'd15, 16'h13),   32'h0000_0013, 32'h0, 32'h0, 32'hA000_0007, 2'd0, 0, 32'h0000_0012, 5'd15, 1'b1};
      vecs[8]  = '{"addu",    enc_r(6'h21, 5'd3, 5'd4, 5'd5),      32'h0, 32'h0, 32'h0, 32'h0000_0055, 2'd0, 0, 32'h0000_0055, 5'd5,  1'b1};
      vecs[9]  = '{"jal",     {6'h03, 26'h0000C02},                32'h0, 32'h0, 32'h0, 32'h0000_3008, 2'd0, 0, 32'h0000_3008, 5'd31, 1'b1};
      vecs[10] = '{"beq",     enc_i(6'h04, 5'd6, 5'd7, 16'h4),     32'h0, 32'h0, 32'h0, 32'hA000_000A, 2'd0, 0, 32'hA000_000A, 5'd0,  1'b0};
      vecs[11] = '{"jr",      enc_r(6'h08, 5'd31, 5'd0, 5'd0),     32'h0, 32'h0, 32'h0, 32'hA000_000B, 2'd0, 0, 32'hA000_000B, 5'd0,  1'b0};
      vecs[12] = '{"nop",     32'h0,                               32'h0, 32'h0, 32'h0, 32'hA000_000C, 2'd0, 0, 32'hA000_000C, 5'd0,  1'b0};
      vecs[13] = '{"sw4010",  enc_i(6'h2b, 5'd2, 5'd10, 16'h4010), 32'h0000_4010, 32'hCAFE_BABE, 32'h0, 32'hA000_000D, 2'd0, 1, 32'hA000_000D, 5'd0, 1'b0};
      vecs[14] = '{"lwalias", enc_i(6'h23, 5'd2, 5'd16, 16'h10),   32'h0000_0010, 32'h0, 32'h0, 32'hA000_000E, 2'd0, 0, 32'hCAFE_BABE, 5'd16, 1'b1};
      vecs[15] = '{"ori",     enc_i(6'h0d, 5'd1, 5'd3, 16'hF0F0),  32'h0, 32'h0, 32'h0, 32'h0000_F0F1, 2'd0, 0, 32'h0000_F0F1, 5'd3,  1'b1};
      vecs[16] = '{"subu",    enc_r(6'h23, 5'd1, 5'd2, 5'd7),      32'h0, 32'h0, 32'h0, 32'hFFFF_FFFE, 2'd0, 0, 32'hFFFF_FFFE, 5'd7,  1'b1};
      vecs[17] = '{"lui",     enc_i(6'h0f, 5'd0, 5'd4, 16'h1234),  32'h0, 32'h0, 32'h0, 32'h1234_0000, 2'd0, 0, 32'h1234_0000, 5'd4,  1'b1};
      vecs[18] = '{"sw20",    enc_i(6'h2b, 5'd0, 5'd5, 16'h20),    32'h0000_0020, 32'h7777_7777, 32'h0, 32'hA000_0012, 2'd0, 1, 32'hA000_0012, 5'd0, 1'b0};
      vecs[19] = '{"sw20z",   enc_i(6'h2b, 5'd0, 5'd5, 16'h20),    32'h0000_0020, 32'h1111_1111, 32'h2222_2222, 32'hA000_0013, 2'd2, 1, 32'hA000_0013, 5'd0, 1'b0};
      vecs[20] = '{"lw20",    enc_i(6'h23, 5'd0, 5'd6, 16'h20),    32'h0000_0020, 32'h0, 32'h0, 32'hA000_0014, 2'd0, 0, 32'h0000_0000, 5'd6,  1'b1};

      // one reset edge
      reset = 1'b0; Instr = 32'h0; PC = 32'h0000_3000; MemAddr = 32'h0;
      GRFRData2 = 32'h0; W_GRFWData = 32'h0; ALUResult = 32'h0; Trans_MemRD_Sel = 2'd0;
      model_clear();
      @(posedge clk);
      #1;
      reset = 1'b1;

      for (int i = 0; i < 21; i++) begin
         step(vecs[i].name, vecs[i].instr, vecs[i].addr, vecs[i].r2, vecs[i].ww, vecs[i].alu,
              vecs[i].sel, 1'b1, vecs[i].wr, vecs[i].exp_d, vecs[i].exp_wa, vecs[i].exp_rw);
      end

      // reset on the same edge as a store: reset wins and memory is cleared
      step("sw_rst", enc_i(6'h2b, 5'd0, 5'd5, 16'h10), 32'h0000_0010, 32'h5555_AAAA, 32'h0,
           32'hB000_0000, 2'd0, 1'b0, 1, 32'hB000_0000, 5'd0, 1'b0);
      step("lw_post_rst", enc_i(6'h23, 5'd0, 5'd6, 16'h10), 32'h0000_0010, 32'h0, 32'h0,
           32'hB000_0001, 2'd0, 1'b1, 0, 32'h0000_0000, 5'd6, 1'b1);
      step("lw_post_rst3ffc", enc_i(6'h23, 5'd0, 5'd7, 16'h0), 32'h0000_3FFC, 32'h0, 32'h0,
           32'hB000_0002, 2'd0, 1'b1, 0, 32'h0000_0000, 5'd7, 1'b1);

      // randomized traffic against the byte model
      for (int n = 0; n < 400; n++) begin
         k    = int'($urandom_range(0, 13));
         rs   = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
         addr = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 63));
         r2   = $urandom; ww = $urandom; alu = $urandom; sel = 2'($urandom);
         rst  = ($urandom_range(0, 59) != 0);
         wr   = 0; exp_d = alu; exp_wa = 5'd0; exp_rw = 1'b0;
         case (k)
            0: begin instr = enc_i(6'h23, rs, rt, 16'($urandom)); exp_wa = rt; exp_rw = 1'b1; exp_d = model_word(addr); end
            1: begin instr = enc_i(6'h20, rs, rt, 16'($urandom)); exp_wa = rt; exp_rw = 1'b1; exp_d = model_byte(addr); end
            2: begin instr = enc_i(6'h2b, rs, rt, 16'($urandom)); wr = 1; end
            3: begin instr = enc_i(6'h28, rs, rt, 16'($urandom)); wr = 2; end
            4: begin instr = enc_r(6'h21, rs, rt, rd); exp_wa = rd; exp_rw = 1'b1; end
            5: begin instr = enc_r(6'h23, rs, rt, rd); exp_wa = rd; exp_rw = 1'b1; end
            6: begin instr = enc_i(6'h0d, rs, rt, 16'($urandom)); exp_wa = rt; exp_rw = 1'b1; end
            7: begin instr = enc_i(6'h0f, rs, rt, 16'($urandom)); exp_wa = rt; exp_rw = 1'b1; end
            8: begin instr = {6'h03, 26'($urandom)}; exp_wa = 5'd31; exp_rw = 1'b1; end
            9: instr = enc_i(6'h04, rs, rt, 16'($urandom));
            10: instr = {6'h02, 26'($urandom)};
            11: instr = enc_r(6'h08, rs, 5'd0, 5'd0);
            12: instr = 32'h0;
            default: begin
               if ($urandom_range(0, 1) == 0) instr = enc_r(6'h20 | 6'($urandom_range(0, 1) << 1), rs, rt, rd);
               else instr = enc_i(bad_ops[$urandom_range(0, 6)], rs, rt, 16'($urandom));
            end
         endcase
         step("rand", instr, addr, r2, ww, alu, sel, rst, wr, exp_d, exp_wa, exp_rw);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
